regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised general-purpose register file for the pipelined MIPS core, replacing the fixed 32×32, two-read-port file in the ID stage. It is generalised in data width, depth and read-port count. It adds same-cycle write-to-read bypass, so a WB-stage write is visible to the ID-stage read in that same cycle, and a hardwired-zero option. Instead of one output bus per register, it provides a serial debug snapshot port with valid/ready handshake.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i = raddr[i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data; port i = rdata[i*DATA_W +: DATA_W]
- dbg_start  in  1  single-cycle request to begin a snapshot scan
- dbg_ready  in  1  consumer ready for the current debug beat
- dbg_valid  out  1  debug beat present
- dbg_idx  out  ADDR_W  register index of the current beat
- dbg_data  out  DATA_W  contents of register dbg_idx
- dbg_last  out  1  current beat is index 2**ADDR_W-1
- dbg_busy  out  1  scan in progress

## Operation
- Storage: 2**ADDR_W × DATA_W flops. While rst=1 every entry is cleared to 0.
- Write: on a clock edge with we=1 and rst=0, regs[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is dropped.
- Read port i is combinational:
  - If ZERO_REG=1 and the address is 0: returns 0.
  - Else if we=1 and waddr equals the address: returns wdata (bypass).
  - Else: returns the stored value.
- Any number of ports may read the same address.
- Debug FSM has two states, IDLE and SCAN.
  - IDLE: dbg_valid=0 and dbg_busy=0. dbg_start=1 moves to SCAN with idx=0.
  - SCAN: dbg_valid=1 and dbg_busy=1. dbg_data is the stored value of regs[idx], with no bypass. It is a live value: if the register is written while the beat is stalled, the data changes on the next cycle.
  - On dbg_valid && dbg_ready: if idx = max, go to IDLE; otherwise idx <= idx+1.
  - dbg_last = dbg_valid && idx = 2**ADDR_W-1.
- dbg_start is ignored while in SCAN; it is not queued.
- A scan never blocks or stalls register writes or reads.

## Timing
- Read latency: 0 cycles (combinational, including bypass). Write becomes visible in storage at the next edge.
- Reset values: all registers 0, FSM in IDLE, dbg_valid=0, dbg_busy=0, dbg_last=0, dbg_idx=0, dbg_data=0. rdata reflects a zeroed array, except for bypass while rst=1: bypass is suppressed during reset, so rdata=0.
- dbg_start at edge N gives dbg_valid=1 with idx=0 in cycle N+1.
- With dbg_ready held at 1, a full scan takes exactly 2**ADDR_W cycles: one beat per cycle, idx wraps to IDLE after max, not to 0.
- dbg_ready=0 holds dbg_idx; dbg_valid stays 1; no beat is lost.
- rst=1 mid-scan: IDLE on the next edge, dbg_valid=0, no further beats.
- dbg_start in the same cycle as the final accepted beat: ignored; the FSM returns to IDLE, and a new start is needed.
- Write to the register currently shown by the debug port: dbg_data updates in the following cycle.

## Test plan
- Reset then readback:
  - Stimulus: rst=1 for 2 cycles, then read all 32 addresses on both ports.
  - Required: every rdata = 0x00000000.
- Write/read and register 0:
  - Stimulus: write 0xDEADBEEF to r8; write 0x12345678 to r0; next cycle read r8 and r0.
  - Required: r8 = 0xDEADBEEF, r0 = 0x00000000.
- Bypass:
  - Stimulus: in one cycle we=1, waddr=9, wdata=0xA5A5A5A5, raddr port0=9, port1=9.
  - Required: both ports return 0xA5A5A5A5 in that cycle. With ZERO_REG=1 and waddr=0, the same check returns 0.
- Full scan, no stall:
  - Stimulus: preload regs[i]=i*4, pulse dbg_start, hold dbg_ready=1.
  - Required: 32 consecutive beats idx 0..31 with data 0..124; dbg_last only on idx 31; dbg_busy low the cycle after.
- Backpressure and live update:
  - Stimulus: during a scan, hold dbg_ready=0 at idx 5 for 3 cycles and write 0x55 to r5.
  - Required: idx stays 5; data changes to 0x55 one cycle after the write; after release, the next beat is idx 6.
- Reset mid-scan and ignored start:
  - Stimulus: start a scan, assert rst at idx 10; separately, pulse dbg_start at idx 3.
  - Required: after rst, dbg_valid=0 next cycle. The pulse at idx 3 has no effect; the scan completes normally at 31.
- Parameter sweep:
  - Stimulus: repeat the write/read scenario with DATA_W=16, ADDR_W=3, NUM_RD=3.
  - Required: correct results; scan takes exactly 8 beats.

Source files
------------

// File: rtl/regfile_bypass.sv
// Parametrised register file with same-cycle write bypass, optional
// hardwired zero register and a serial valid/ready debug snapshot port.
module regfile_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     dbg_start,
    input  logic                     dbg_ready,
    output logic                     dbg_valid,
    output logic [ADDR_W-1:0]        dbg_idx,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     dbg_last,
    output logic                     dbg_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [ADDR_W-1:0] IDX_MAX = '1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              wr_ok;

    assign wr_ok = we && !(ZR && waddr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        assign a = raddr[i*ADDR_W +: ADDR_W];

        // Bypass is held off during reset so reads see the cleared array.
        always_comb begin
            d = regs[a];
            if (ZR && a == '0) begin
                d = '0;
            end else if (we && !rst && waddr == a) begin
                d = wdata;
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_start) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (dbg_ready) begin
                        if (idx == IDX_MAX) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Debug data is the live stored value, never the bypassed one.
    assign dbg_valid = (state == SCAN);
    assign dbg_busy  = (state == SCAN);
    assign dbg_idx   = idx;
    assign dbg_data  = dbg_valid ? regs[idx] : '0;
    assign dbg_last  = dbg_valid && (idx == IDX_MAX);

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: reads, bypass, zero register,
// debug scans with backpressure/reset, and a narrow parameter set.
module tb_regfile_bypass;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        dbg_start, dbg_ready;
    logic        dbg_valid, dbg_last, dbg_busy;
    logic [4:0]  dbg_idx;
    logic [31:0] dbg_data;

    logic        we2;
    logic [2:0]  waddr2;
    logic [15:0] wdata2;
    logic [8:0]  raddr2;
    logic [47:0] rdata2;
    logic        dbg_start2, dbg_ready2;
    logic        dbg_valid2, dbg_last2, dbg_busy2;
    logic [2:0]  dbg_idx2;
    logic [15:0] dbg_data2;

    regfile_bypass u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata),
        .dbg_start(dbg_start), .dbg_ready(dbg_ready),
        .dbg_valid(dbg_valid), .dbg_idx(dbg_idx), .dbg_data(dbg_data),
        .dbg_last(dbg_last), .dbg_busy(dbg_busy)
    );

    regfile_bypass #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1)) u_dut2 (
        .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .raddr(raddr2), .rdata(rdata2),
        .dbg_start(dbg_start2), .dbg_ready(dbg_ready2),
        .dbg_valid(dbg_valid2), .dbg_idx(dbg_idx2), .dbg_data(dbg_data2),
        .dbg_last(dbg_last2), .dbg_busy(dbg_busy2)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [32];
    logic [15:0] m2 [8];

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        we    = 1'b1;
        waddr = 5'(a);
        wdata = d;
        step();
        we = 1'b0;
        if (a != 0) mdl[a] = d;
    endtask

    task automatic chk_dbg(input int b);
        expect_v("dbg_valid", 32'd1);
        compare({31'b0, dbg_valid});
        expect_v("dbg_idx", 32'(b));
        compare({27'b0, dbg_idx});
        expect_v("dbg_data", mdl[b]);
        compare(dbg_data);
        expect_v("dbg_last", {31'b0, (b == 31)});
        compare({31'b0, dbg_last});
    endtask

    task automatic chk_idle();
        expect_v("idle_valid", 32'd0);
        compare({31'b0, dbg_valid});
        expect_v("idle_busy", 32'd0);
        compare({31'b0, dbg_busy});
        expect_v("idle_last", 32'd0);
        compare({31'b0, dbg_last});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        dbg_start = 1'b0; dbg_ready = 1'b0;
        we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
        dbg_start2 = 1'b0; dbg_ready2 = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int i = 0; i < 8; i++) m2[i] = '0;

        // reset state, bypass suppressed while rst=1
        step();
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0001;
        raddr = {5'd3, 5'd3};
        #1;
        expect_v("rst_bypass_p0", 32'h0);
        compare(rdata[31:0]);
        expect_v("rst_bypass_p1", 32'h0);
        compare(rdata[63:32]);
        chk_idle();
        expect_v("rst_idx", 32'h0);
        compare({27'b0, dbg_idx});
        expect_v("rst_data", 32'h0);
        compare(dbg_data);
        step();
        rst = 1'b0;
        we  = 1'b0;

        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            expect_v("readback_p0", 32'h0);
            compare(rdata[31:0]);
            expect_v("readback_p1", 32'h0);
            compare(rdata[63:32]);
        end

        // write/read and the zero register
        wr(8, 32'hDEADBEEF);
        wr(0, 32'h12345678);
        raddr = {5'd0, 5'd8};
        #1;
        expect_v("rd_r8", 32'hDEADBEEF);
        compare(rdata[31:0]);
        expect_v("rd_r0", 32'h0);
        compare(rdata[63:32]);

        // same-cycle bypass
        step();
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
        raddr = {5'd9, 5'd9};
        #1;
        expect_v("bypass_p0", 32'hA5A5A5A5);
        compare(rdata[31:0]);
        expect_v("bypass_p1", 32'hA5A5A5A5);
        compare(rdata[63:32]);
        waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
        #1;
        expect_v("bypass_r0_p0", 32'h0);
        compare(rdata[31:0]);
        expect_v("bypass_r0_p1", 32'h0);
        compare(rdata[63:32]);
        waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr = {5'd9, 5'd9};
        step();
        we = 1'b0;
        mdl[9] = 32'hA5A5A5A5;
        #1;
        expect_v("stored_r9", 32'hA5A5A5A5);
        compare(rdata[31:0]);

        // full scan without stalls
        for (int i = 0; i < 32; i++) wr(i, 32'(i * 4));
        dbg_ready = 1'b1;
        dbg_start = 1'b1;
        step();
        dbg_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk_dbg(b);
            step();
        end
        chk_idle();

        // backpressure at idx 5 with a live write
        dbg_start = 1'b1;
        step();
        dbg_start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk_dbg(b);
            step();
        end
        dbg_ready = 1'b0;
        chk_dbg(5);
        we = 1'b1; waddr = 5'd5; wdata = 32'h55;
        step();
        we = 1'b0;
        mdl[5] = 32'h55;
        chk_dbg(5);
        step();
        chk_dbg(5);
        dbg_ready = 1'b1;
        step();
        for (int b = 6; b < 32; b++) begin
            chk_dbg(b);
            step();
        end
        chk_idle();

        // start pulses inside a scan and on the final beat are ignored
        dbg_start = 1'b1;
        step();
        dbg_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk_dbg(b);
            if (b == 3 || b == 31) dbg_start = 1'b1;
            step();
            dbg_start = 1'b0;
        end
        chk_idle();
        step();
        chk_idle();

        // reset in the middle of a scan
        dbg_start = 1'b1;
        step();
        dbg_start = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            chk_dbg(b);
            if (b == 10) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        chk_idle();
        expect_v("rst_mid_idx", 32'h0);
        compare({27'b0, dbg_idx});
        step();
        chk_idle();
        raddr = {5'd9, 5'd8};
        #1;
        expect_v("rst_mid_r8", 32'h0);
        compare(rdata[31:0]);

        // narrow configuration: 16-bit, 8 entries, 3 read ports
        step();
        we2 = 1'b1; waddr2 = 3'd3; wdata2 = 16'hBEEF;
        step();
        m2[3] = 16'hBEEF;
        waddr2 = 3'd0; wdata2 = 16'h1234;
        step();
        we2 = 1'b0;
        raddr2 = {3'd3, 3'd0, 3'd3};
        #1;
        expect_v("p2_rd0", 32'hBEEF);
        compare({16'b0, rdata2[15:0]});
        expect_v("p2_rd1", 32'h0);
        compare({16'b0, rdata2[31:16]});
        expect_v("p2_rd2", 32'hBEEF);
        compare({16'b0, rdata2[47:32]});
        we2 = 1'b1; waddr2 = 3'd6; wdata2 = 16'h5A5A;
        raddr2 = {3'd1, 3'd6, 3'd6};
        #1;
        expect_v("p2_byp0", 32'h5A5A);
        compare({16'b0, rdata2[15:0]});
        expect_v("p2_byp1", 32'h5A5A);
        compare({16'b0, rdata2[31:16]});
        expect_v("p2_byp2", 32'h0);
        compare({16'b0, rdata2[47:32]});
        step();
        we2 = 1'b0;
        m2[6] = 16'h5A5A;

        dbg_ready2 = 1'b1;
        dbg_start2 = 1'b1;
        step();
        dbg_start2 = 1'b0;
        n = 0;
        while (dbg_valid2 && n < 20) begin
            expect_v("p2_idx", 32'(n));
            compare({29'b0, dbg_idx2});
            expect_v("p2_data", {16'b0, m2[n % 8]});
            compare({16'b0, dbg_data2});
            expect_v("p2_last", {31'b0, (n == 7)});
            compare({31'b0, dbg_last2});
            n++;
            step();
        end
        expect_v("p2_beats", 32'd8);
        compare(32'(n));
        expect_v("p2_busy_after", 32'd0);
        compare({31'b0, dbg_busy2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
